// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//
// Multi-mode barrel shifter for N-bit operands: logical left, logical right,
// arithmetic right and rotate-left by 0..N-1, plus the last bit shifted out.
// Timing:
//   - An accepted operand is first captured in an acceptance register.
//   - It then passes through S = log2(N) registered mux rows.
//   - Out_valid rises S edges after the accepting edge.
// The whole pipe freezes while the consumer stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every stage register
//   in         operand (N bits)
//   amt        shift amount, unsigned, 0..N-1 (S bits)
//   mode       00 LSL, 01 LSR, 10 ASR, 11 ROL
//   in_valid   in/amt/mode are valid
//   in_ready   operand can be accepted this cycle (low while stalled)
//   out        shifted result, straight from the final stage register
//   out_carry  last bit shifted or rotated out (0 when amt = 0)
//   out_valid  out/out_carry are valid
//   out_ready  consumer takes the result on this edge

module pipelined_barrel_shifter #(
  parameter int N = 8,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic [S-1:0] amt,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic         out_carry,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One mux row: shift the word by a fixed distance according to the mode.
  function automatic logic [N-1:0] shift_row(input logic [N-1:0] d,
                                             input logic [1:0]   m,
                                             input int           sh);
    logic [N-1:0] r;
    r = d;
    case (m)
      MODE_LSL: r = d << sh;
      MODE_LSR: r = d >> sh;
      MODE_ASR: r = $signed(d) >>> sh;
      default:  r = (d << sh) | (d >> (N - sh));
    endcase
    return r;
  endfunction

  logic         stall;
  logic [S-1:0] lsl_idx;
  logic [S-1:0] lsr_idx;
  logic         carry_in;

  // The carry depends on the full amount, so it is resolved once at
  // acceptance and then travels with the word. Both index expressions wrap
  // modulo N, which gives N-k and k-1 directly for k = 1..N-1.
  always_comb begin
    lsl_idx  = S'(N) - amt;
    lsr_idx  = amt - S'(1);
    carry_in = 1'b0;
    if (amt != '0) begin
      if ((mode == MODE_LSL) || (mode == MODE_ROL)) begin
        carry_in = in[lsl_idx];
      end else begin
        carry_in = in[lsr_idx];
      end
    end
  end

  // Whole-pipe freeze: no bubble squeezing, so a single enable covers
  // every stage.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage 0 is the acceptance register; stage gi (gi >= 1) holds the output
  // of the mux row that shifts by 2^(gi-1) when amt bit gi-1 is set.
  for (genvar gi = 0; gi <= S; gi++) begin : g_stage
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;
    logic [1:0]   mode_q;
    logic [1:0]   mode_d;
    logic [S-1:0] amt_q;
    logic [S-1:0] amt_d;
    logic         carry_q;
    logic         carry_d;
    logic         valid_q;
    logic         valid_d;

    if (gi == 0) begin : g_accept
      always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        amt_d   = amt_q;
        carry_d = carry_q;
        valid_d = valid_q;
        if (!stall) begin
          data_d  = in;
          mode_d  = mode;
          amt_d   = amt;
          carry_d = carry_in;
          valid_d = in_valid;
        end
      end
    end else begin : g_row
      always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        amt_d   = amt_q;
        carry_d = carry_q;
        valid_d = valid_q;
        if (!stall) begin
          data_d  = g_stage[gi-1].amt_q[gi-1]
                  ? shift_row(g_stage[gi-1].data_q, g_stage[gi-1].mode_q, 1 << (gi - 1))
                  : g_stage[gi-1].data_q;
          mode_d  = g_stage[gi-1].mode_q;
          amt_d   = g_stage[gi-1].amt_q;
          carry_d = g_stage[gi-1].carry_q;
          valid_d = g_stage[gi-1].valid_q;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        mode_q  <= '0;
        amt_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        mode_q  <= mode_d;
        amt_q   <= amt_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end
  end

  assign out       = g_stage[S].data_q;
  assign out_carry = g_stage[S].carry_q;
  assign out_valid = g_stage[S].valid_q;

  // Mode and amount are fully consumed by the last row; the final copies
  // are kept only so every stage register has the same shape.
  logic unused_tail;
  assign unused_tail = ^{g_stage[S].amt_q, g_stage[S].mode_q};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter
//
// Self-checking bench for pipelined_barrel_shifter (N = 8).
// Behaviour:
//   - Every accepted operand is modelled with plain wide-word arithmetic.
//   - The modelled result is queued at acceptance.
//   - Each consumed result is popped from the queue and compared.
// Phases: reset, directed vectors, reset mid-flight, streaming, and random
// traffic with forced backpressure.

module tb_pipelined_barrel_shifter;

  localparam int N = 8;
  localparam int S = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] tb_in;
  logic [S-1:0] tb_amt;
  logic [1:0]   tb_mode;
  logic         tb_in_valid;
  logic         in_ready;
  logic [N-1:0] out;
  logic         out_carry;
  logic         out_valid;
  logic         tb_out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] d;
    logic         c;
  } exp_t;

  exp_t exp_q[$];

  logic         prev_stall = 1'b0;
  logic [N-1:0] held_d;
  logic         held_c;
  int           stall_cycles = 0;
  int           n_out = 0;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (tb_in),
    .amt       (tb_amt),
    .mode      (tb_mode),
    .in_valid  (tb_in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_carry (out_carry),
    .out_valid (out_valid),
    .out_ready (tb_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: shift inside a double-width word so shifted-out bits stay
  // visible; the bit just across the boundary is the carry. Rotation is done
  // one bit at a time, remembering the bit that wrapped.
  function automatic exp_t ref_model(input logic [N-1:0] a, input int k, input logic [1:0] m);
    logic [2*N-1:0] w;
    exp_t r;
    r.d = a;
    r.c = 1'b0;
    case (m)
      2'b00: begin
        w = {{N{1'b0}}, a};
        w = w << k;
        r.d = w[N-1:0];
        if (k != 0) r.c = w[N];
      end
      2'b01: begin
        w = {a, {N{1'b0}}};
        w = w >> k;
        r.d = w[2*N-1:N];
        if (k != 0) r.c = w[N-1];
      end
      2'b10: begin
        w = {a, {N{1'b0}}};
        w = $signed(w) >>> k;
        r.d = w[2*N-1:N];
        if (k != 0) r.c = w[N-1];
      end
      default: begin
        for (int i = 0; i < k; i++) begin
          r.c = r.d[N-1];
          r.d = {r.d[N-2:0], r.d[N-1]};
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: handshakes are sampled on the falling edge, where they equal
  // what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_out", out, held_d);
        check_eq("stall_carry", out_carry, held_c);
        check_eq("stall_valid", out_valid, 1);
      end
      check_eq("in_ready", in_ready, !(out_valid && !tb_out_ready));
      if (out_valid && tb_out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("out", out, e.d);
          check_eq("carry", out_carry, e.c);
          n_out++;
          $display("result %0d: out=%02h carry=%0d (model %02h/%0d)", n_out, out, out_carry, e.d, e.c);
        end
      end
      if (tb_in_valid && in_ready) begin
        exp_q.push_back(ref_model(tb_in, int'(tb_amt), tb_mode));
      end
      prev_stall = out_valid && !tb_out_ready;
      held_d     = out;
      held_c     = out_carry;
      if (prev_stall) stall_cycles++;
    end
  end

  task automatic wait_empty(input string tag);
    int c;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_directed(input string tag, input logic [N-1:0] a, input logic [S-1:0] k,
                              input logic [1:0] m, input logic [N-1:0] ed, input logic ec);
    int lat;
    tb_out_ready = 1'b1;
    @(posedge clk); #1;
    tb_in = a; tb_amt = k; tb_mode = m; tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    for (lat = 0; lat < 12; lat++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_eq({tag, "_latency"}, lat, S);
    check_eq({tag, "_out"}, out, ed);
    check_eq({tag, "_carry"}, out_carry, ec);
    $display("directed %s: out=%02h carry=%0d after %0d edges", tag, out, out_carry, lat);
  endtask

  initial begin
    int first, last, nvalid, stall_left, c;
    rst_n = 1'b0;
    tb_in = '0; tb_amt = '0; tb_mode = '0; tb_in_valid = 1'b0; tb_out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", out, 0);
    check_eq("reset_carry", out_carry, 0);
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;

    // Directed vectors.
    run_directed("lsl1", 8'b10101110, 3'd1, 2'b00, 8'b01011100, 1'b1);
    run_directed("lsl0", 8'b10101110, 3'd0, 2'b00, 8'b10101110, 1'b0);
    run_directed("asr3", 8'b10101110, 3'd3, 2'b10, 8'b11110101, 1'b1);
    run_directed("lsr4", 8'b00101111, 3'd4, 2'b01, 8'b00000010, 1'b1);
    run_directed("rol3", 8'b00101111, 3'd3, 2'b11, 8'b01111001, 1'b1);
    run_directed("rol7", 8'b10000000, 3'd7, 2'b11, 8'b01000000, 1'b0);
    run_directed("ror0", 8'b10000001, 3'd0, 2'b11, 8'b10000001, 1'b0);
    wait_empty("directed");

    // Reset mid-flight: first operand parked at the output under a stall.
    tb_out_ready = 1'b0;
    @(posedge clk); #1;
    tb_in = 8'b10101110; tb_amt = 3'd1; tb_mode = 2'b00; tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in = 8'b00101111; tb_amt = 3'd3; tb_mode = 2'b11;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    for (c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_eq("rst_pre_valid", out_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("rst_mid_out", out, 0);
    check_eq("rst_mid_carry", out_carry, 0);
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_valid", out_valid, 0);
    #2 rst_n = 1'b1;
    tb_out_ready = 1'b1;
    nvalid = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check_eq("rst_no_leftover", nvalid, 0);

    // Streaming: eight back-to-back LSL operands.
    first = -1; last = -1; nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        tb_in = N'(1 << i); tb_amt = S'(i); tb_mode = 2'b00; tb_in_valid = 1'b1;
      end else begin
        tb_in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        nvalid++;
      end
    end
    check_eq("stream_first", first, 1 + S);
    check_eq("stream_count", nvalid, 8);
    check_eq("stream_contig", last - first + 1, 8);
    wait_empty("stream");

    // Random traffic with forced two-cycle stalls.
    stall_left = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      tb_in       = N'($urandom);
      tb_amt      = S'($urandom_range(0, N - 1));
      tb_mode     = 2'($urandom);
      tb_in_valid = ($urandom_range(0, 3) != 0);
      if (stall_left > 0) begin
        tb_out_ready = 1'b0;
        stall_left--;
      end else if (out_valid && ($urandom_range(0, 5) == 0)) begin
        tb_out_ready = 1'b0;
        stall_left = 1;
      end else begin
        tb_out_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    wait_empty("random");
    check_eq("stalls_exercised", stall_cycles > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

A parametrised, multi-mode barrel shifter for N-bit operands. It supports logical left, logical right, arithmetic right and rotate-left by any amount from 0 to N-1, and reports the last bit shifted out. The datapath is a log2(N)-stage mux network with a register after every stage, so it accepts one operand per cycle. Valid/ready handshakes on both sides let it sit between pipelined producers and consumers in the datapath, replacing the fixed single-bit shift mux row.

## Interface

- N, default 8: operand width. Must be a power of two, at least 2.
- S, default $clog2(N): shift-amount width and number of pipeline stages. Derived from N; never overridden.

- Clk, input, 1: clock. All state updates on the rising edge.
- Rst_n, input, 1: reset, asynchronous and active-low.
- In, input, N: operand.
- Amt, input, S: shift amount, unsigned, 0..N-1.
- Mode, input, 2: 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROL.
- In_valid, input, 1: In, Amt and Mode are valid.
- In_ready, output, 1: shifter can accept an operand this cycle.
- Out, output, N: shifted result.
- Out_carry, output, 1: last bit shifted or rotated out.
- Out_valid, output, 1: Out and Out_carry are valid.
- Out_ready, input, 1: consumer accepts the result.

## Operation

- **Accept.** An operand is accepted on a rising edge with In_valid && In_ready. Inputs are ignored when In_valid is low or In_ready is low.
- **Carry computation.** Out_carry is computed from In and Amt at acceptance, then carried down the pipeline with the data.
  - k = 0: carry = 0.
  - LSL / ROL: carry = In[N-k].
  - LSR / ASR: carry = In[k-1].
- **Stages.** Stage j (j = 0..S-1) shifts by 2^j when Amt[j] = 1; otherwise it passes the word through unchanged. Each stage's register holds the data word, Mode, the remaining Amt bits, the carry and a valid bit.
- **Fill rules.**
  - LSL and LSR fill with 0.
  - ASR fills with the operand's bit N-1 (sign), which is preserved through every stage.
  - ROL wraps the bits shifted out of the top back into the bottom.
- **Amt = 0.** Out = In, Out_carry = 0, for every mode.
- **Stall.** stall = Out_valid && !Out_ready.
  - In_ready = !stall.
  - When stall is high, every stage register holds its value.
  - Bubbles are not compressed during a stall; whole-pipe freeze only.
  - A result is consumed on an edge where Out_valid && Out_ready.
- **Results.** Results emerge strictly in acceptance order, with no loss and no duplication.
- **Outputs.** Out, Out_carry and Out_valid are driven directly from the final stage register.

## Timing

- **Reset.** Rst_n low immediately clears all stage valid bits, data, Amt, Mode and carry registers to 0.
  - Out = 0, Out_carry = 0, Out_valid = 0, In_ready = 1, held while Rst_n is low.
  - Reset mid-stream discards every in-flight operand.
  - The first accept occurs on the first rising edge after Rst_n is released with In_valid = 1.
- **Latency.** S cycles: an operand accepted at edge t gives Out_valid = 1 after edge t+S (3 cycles for N = 8), assuming no stall.
- **Throughput.** One result per cycle while Out_ready = 1.
- **Stall timing.** When Out_ready drops while Out_valid = 1:
  - Out and Out_carry stay stable from that cycle until the consuming edge.
  - In_ready is low in the same cycle (combinational from Out_valid and Out_ready).
- **Simultaneous consume and accept.** When Out_valid && Out_ready && In_valid on the same edge, the pipeline advances, the output is consumed and the new operand enters stage 0 in that single edge.
- **Reset priority.** Reset takes priority over all handshakes.

## Test plan

1. **Reset.** Send 2 operands, then pulse Rst_n low mid-flight -> Out = 0, Out_valid = 0, Out_carry = 0, In_ready = 1 immediately; neither operand is ever output.
2. **LSL, N = 8.** In = 8'b10101110, Amt = 1, Mode = 00 -> after 3 cycles Out = 8'b01011100, Out_carry = 1. With Amt = 0 -> Out = 8'b10101110, Out_carry = 0.
3. **ASR / LSR.** In = 8'b10101110, Amt = 3, Mode = 10 -> Out = 8'b11110101, Out_carry = 1. In = 8'b00101111, Amt = 4, Mode = 01 -> Out = 8'b00000010, Out_carry = 1.
4. **ROL.** In = 8'b00101111, Amt = 3, Mode = 11 -> Out = 8'b01111001, Out_carry = 1. In = 8'b10000000, Amt = 7 -> Out = 8'b01000000, Out_carry = 0.
5. **Streaming.** 8 back-to-back operands (In = 1<<i, Amt = i, LSL), Out_ready = 1 -> 8 consecutive Out_valid cycles starting 3 cycles after the first accept, in order, matching the reference model.
6. **Backpressure.** Random In_valid plus Out_ready held low 2 cycles while Out_valid = 1:
   - Out stays stable and In_ready = 0 during the stall.
   - The scoreboard sees every operand exactly once, in order, bit-exact against the reference model for all 4 modes and all Amt values.
